// File: rtl/ring_pkg.sv
// Shared definitions for the ring unloader: FSM states, default geometry
// and the reset pattern loaded into the slots.
package ring_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 2;
    localparam int DEFAULT_DEPTH = 3;

    // Reset value for a slot; callers truncate to WIDTH, so values wrap mod 2^WIDTH.
    function automatic logic [31:0] reset_value(input int idx);
        return 32'(idx + 1);
    endfunction

endpackage

// File: rtl/ring_slot_bank.sv
// DEPTH x WIDTH storage for the ring: synchronous reset to the reset
// pattern, parallel load, and a simultaneous rotate-down (slot i <- slot i+1,
// last slot <- slot 0).
module ring_slot_bank
    import ring_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    input  logic                   rotate,
    output logic [DEPTH*WIDTH-1:0] ring_q
);

    logic [WIDTH-1:0] slots [DEPTH];

    // Slot update: reset pattern, parallel load, or one-step rotation, all slots at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= WIDTH'(reset_value(i));
            end
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= load_data[i*WIDTH +: WIDTH];
            end
        end else if (rotate) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= slots[(i + 1) % DEPTH];
            end
        end
    end

    // Pack the slots into the flat live view, slot 0 in the low bits.
    always_comb begin
        ring_q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ring_q[i*WIDTH +: WIDTH] = slots[i];
        end
    end

endmodule

// File: rtl/ring_unloader.sv
// Parallel-load, serial-unload ring register. A single load beat captures
// DEPTH words; the ring then rotates down once per accepted output beat so
// slot 0 always presents the next word. After DEPTH beats the ring is back
// in its loaded order.
// Optional macro RING_UNLOADER_REPLAY_EN adds a replay input that re-emits
// the last loaded burst without reloading.
module ring_unloader
    import ring_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [DEPTH*WIDTH-1:0] load_data,
`ifdef RING_UNLOADER_REPLAY_EN
    input  logic                   replay,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [DEPTH*WIDTH-1:0] ring_q,
    output logic                   busy
);

    localparam int CNT_W = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_load;
    logic             do_rotate;

    ring_slot_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .load      (do_load),
        .load_data (load_data),
        .rotate    (do_rotate),
        .ring_q    (ring_q)
    );

    // State and beat counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: load (or replay) starts a burst, each accepted beat rotates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_load   = 1'b0;
        do_rotate = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    do_load = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
`ifdef RING_UNLOADER_REPLAY_EN
                else if (replay) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
`endif
            end
            SHIFT: begin
                if (out_ready) begin
                    do_rotate = 1'b1;
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stream outputs are pure functions of the registered state.
    always_comb begin
        load_ready = (state_q == IDLE);
        out_valid  = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        out_last   = (state_q == SHIFT) && (cnt_q == CNT_W'(DEPTH - 1));
        out_data   = ring_q[WIDTH-1:0];
    end

endmodule
